// File: rtl/util_delay_sched.sv
// Writeback-slot scheduler: grants fixed-latency ops so no two ops retire in the same cycle.
// Optional round-robin requester priority is enabled by defining UTIL_DELAY_SCHED_RR_EN.
module util_delay_sched #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 7,
  parameter int LATW  = 3,
  parameter int TAGW  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*LATW-1:0] i_req_lat,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_done,
  output logic [TAGW-1:0]      o_done_tag,
  output logic                 o_busy,
  output logic                 o_lat_err
);

  localparam int NSLOT = 2 ** LATW;

  logic [DEPTH-1:0] r_v;
  logic [TAGW-1:0]  r_t [DEPTH];
`ifdef UTIL_DELAY_SCHED_RR_EN
  logic [TAGW-1:0]  r_p;
  logic [TAGW-1:0]  w_p_next;
`endif

  logic [NSLOT-1:0] w_vx;
  logic [NSLOT-1:0] w_claimed;
  logic [LATW-1:0]  w_lat [NREQ];
  logic [NREQ-1:0]  w_gnt;
  logic             w_lat_err;

  // Slot DEPTH lies beyond the shift register and always reads as free.
  assign w_vx = NSLOT'(r_v);

  // Grant arbitration in priority order; each latency slot is claimed at most once per cycle.
  always_comb begin
    w_gnt     = '0;
    w_claimed = '0;
    w_lat_err = 1'b0;
`ifdef UTIL_DELAY_SCHED_RR_EN
    w_p_next  = r_p;
`endif
    for (int i = 0; i < NREQ; i++) begin
      w_lat[i] = i_req_lat[i*LATW +: LATW];
    end
    for (int k = 0; k < NREQ; k++) begin
      int   idx;
      logic legal;
      logic ok;
`ifdef UTIL_DELAY_SCHED_RR_EN
      idx = (int'(r_p) + k) % NREQ;
`else
      idx = k;
`endif
      legal     = (w_lat[idx] != LATW'(0)) && (int'(w_lat[idx]) <= DEPTH);
      w_lat_err = w_lat_err | (i_rst_n & i_req[idx] & ~legal);
      ok        = i_rst_n & i_req[idx] & legal & ~i_stall
                  & ~w_vx[w_lat[idx]] & ~w_claimed[w_lat[idx]];
      w_gnt[idx]             = ok;
      w_claimed[w_lat[idx]]  = w_claimed[w_lat[idx]] | ok;
`ifdef UTIL_DELAY_SCHED_RR_EN
      w_p_next = ok ? TAGW'((idx + 1) % NREQ) : w_p_next;
`endif
    end
  end

  assign o_gnt      = w_gnt;
  assign o_lat_err  = w_lat_err;
  assign o_done     = r_v[0] & ~i_stall;
  assign o_done_tag = r_t[0];
  assign o_busy     = |r_v;

  // Reservation shift register: shift toward retirement, then book newly granted slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_t[k] <= '0;
      end
`ifdef UTIL_DELAY_SCHED_RR_EN
      r_p <= '0;
`endif
    end else if (!i_stall) begin
      r_v <= {1'b0, r_v[DEPTH-1:1]};
      for (int k = 0; k < DEPTH-1; k++) begin
        r_t[k] <= r_t[k+1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_v[w_lat[i] - LATW'(1)] <= 1'b1;
          r_t[w_lat[i] - LATW'(1)] <= TAGW'(i);
        end
      end
`ifdef UTIL_DELAY_SCHED_RR_EN
      r_p <= w_p_next;
`endif
    end
  end

endmodule

// File: tb/tb_util_delay_sched.sv
// Directed self-checking bench for util_delay_sched (default parameters).
module tb_util_delay_sched;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic [1:0] req;
  logic [5:0] req_lat;
  logic [1:0] gnt;
  logic       done;
  logic [0:0] done_tag;
  logic       busy;
  logic       lat_err;

  int checks   = 0;
  int failures = 0;

  util_delay_sched dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_stall    (stall),
    .i_req      (req),
    .i_req_lat  (req_lat),
    .o_gnt      (gnt),
    .o_done     (done),
    .o_done_tag (done_tag),
    .o_busy     (busy),
    .o_lat_err  (lat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle, leaving 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    stall = 1'b0;
    req_lat = 6'd0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] lats(input logic [2:0] l1, input logic [2:0] l0);
    return {l1, l0};
  endfunction

  initial begin
    rst_n   = 1'b0;
    stall   = 1'b0;
    req     = 2'b11;
    req_lat = lats(3'd1, 3'd0);
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_lat_err", 32'(lat_err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tag", 32'(done_tag), 32'd0);

    // 1. single op L=3
    do_reset();
    req = 2'b01; req_lat = lats(3'd0, 3'd3); #1;
    chk("t1_gnt", 32'(gnt), 32'b01);
    chk("t1_busy0", 32'(busy), 32'd0);
    tick(); req = 2'b00;
    chk("t1_c1_done", 32'(done), 32'd0);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c2_done", 32'(done), 32'd0);
    chk("t1_c2_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c3_done", 32'(done), 32'd1);
    chk("t1_c3_tag", 32'(done_tag), 32'd0);
    chk("t1_c3_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c4_done", 32'(done), 32'd0);
    chk("t1_c4_busy", 32'(busy), 32'd0);

    // 2. slot conflict, both L=2
    do_reset();
    req = 2'b11; req_lat = lats(3'd2, 3'd2); #1;
    chk("t2_c0_gnt", 32'(gnt), 32'b01);
    tick(); req = 2'b10; #1;
    chk("t2_c1_gnt", 32'(gnt), 32'b10);
    tick(); req = 2'b00;
    chk("t2_c2_done", 32'(done), 32'd1);
    chk("t2_c2_tag", 32'(done_tag), 32'd0);
    tick();
    chk("t2_c3_done", 32'(done), 32'd1);
    chk("t2_c3_tag", 32'(done_tag), 32'd1);
    tick();
    chk("t2_c4_done", 32'(done), 32'd0);

    // 3. distinct latencies: req0 L=4, req1 L=1
    do_reset();
    req = 2'b11; req_lat = lats(3'd1, 3'd4); #1;
    chk("t3_gnt", 32'(gnt), 32'b11);
    tick(); req = 2'b00;
    chk("t3_p1_done", 32'(done), 32'd1);
    chk("t3_p1_tag", 32'(done_tag), 32'd1);
    tick();
    chk("t3_p2_done", 32'(done), 32'd0);
    tick();
    chk("t3_p3_done", 32'(done), 32'd0);
    tick();
    chk("t3_p4_done", 32'(done), 32'd1);
    chk("t3_p4_tag", 32'(done_tag), 32'd0);

    // 4. stall: grant L=2, stall cycles 1-3
    do_reset();
    req = 2'b01; req_lat = lats(3'd0, 3'd2); #1;
    chk("t4_c0_gnt", 32'(gnt), 32'b01);
    tick(); stall = 1'b1; req = 2'b10; req_lat = lats(3'd1, 3'd0); #1;
    chk("t4_c1_gnt", 32'(gnt), 32'b00);
    chk("t4_c1_done", 32'(done), 32'd0);
    req = 2'b00;
    tick();
    chk("t4_c2_done", 32'(done), 32'd0);
    tick();
    chk("t4_c3_done", 32'(done), 32'd0);
    chk("t4_c3_busy", 32'(busy), 32'd1);
    tick(); stall = 1'b0; #1;
    chk("t4_c4_done", 32'(done), 32'd0);
    tick();
    chk("t4_c5_done", 32'(done), 32'd1);
    stall = 1'b1; #1;
    chk("t4_c5_stall_done", 32'(done), 32'd0);
    tick(); stall = 1'b0; #1;
    chk("t4_c6_done", 32'(done), 32'd1);
    chk("t4_c6_tag", 32'(done_tag), 32'd0);
    tick();
    chk("t4_c7_done", 32'(done), 32'd0);

    // 5a. illegal latency
    do_reset();
    req = 2'b01; req_lat = lats(3'd0, 3'd0); #1;
    chk("t5_l0_gnt", 32'(gnt), 32'd0);
    chk("t5_l0_err", 32'(lat_err), 32'd1);
    req = 2'b11; req_lat = lats(3'd0, 3'd3); #1;
    chk("t5_mix_gnt", 32'(gnt), 32'b01);
    chk("t5_mix_err", 32'(lat_err), 32'd1);
    req = 2'b01; req_lat = lats(3'd0, 3'd7); #1;
    chk("t5_l7_err", 32'(lat_err), 32'd0);
    chk("t5_l7_gnt", 32'(gnt), 32'b01);
    // 5b. reset mid-operation after an L=5 grant
    do_reset();
    req = 2'b01; req_lat = lats(3'd0, 3'd5); #1;
    chk("t5_rst_gnt", 32'(gnt), 32'b01);
    tick(); req = 2'b00;
    chk("t5_c1_busy", 32'(busy), 32'd1);
    tick(); rst_n = 1'b0; req = 2'b01; req_lat = lats(3'd0, 3'd1); #1;
    chk("t5_inrst_busy", 32'(busy), 32'd0);
    chk("t5_inrst_gnt", 32'(gnt), 32'd0);
    req = 2'b00;
    rst_n = 1'b1;
    for (int c = 3; c <= 8; c++) begin
      tick();
      chk($sformatf("t5_after_rst_done_c%0d", c), 32'(done), 32'd0);
    end

    // 6. both requesters L=1 for 4 cycles
    do_reset();
    req = 2'b11; req_lat = lats(3'd1, 3'd1);
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef UTIL_DELAY_SCHED_RR_EN
      chk($sformatf("t6_gnt_c%0d", c), 32'(gnt), (c % 2 == 0) ? 32'b01 : 32'b10);
`else
      chk($sformatf("t6_gnt_c%0d", c), 32'(gnt), 32'b01);
`endif
      tick();
    end
    req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
